subbytes_seq: RTL and testbench

Parametrised, handshaked AES SubBytes engine. It time-multiplexes LANES synchronous S-box lanes across the 16 bytes of a 128-bit state, so area trades against latency. It sits between the round-key/state register and ShiftRows in the AES core, replacing the fixed 16-lane, always-on substitution with a valid/ready stage that also holds its result until the consumer takes it.

---
 rtl/aes_pkg.sv | 21 ++
 rtl/sbox_lane.sv | 63 ++++++
 rtl/subbytes_seq.sv | 163 ++++++++++++++++
 tb/tb_subbytes_seq.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES types, FSM state encoding and parameter checks for the SubBytes engine.
// Optional feature macro: SUBBYTES_INV_EN (adds inverse S-box and decrypt select).
package aes_pkg;

  typedef logic [127:0] aes_state_t;
  typedef logic [7:0]   aes_byte_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sb_state_e;

  // Lane counts must divide the 16-byte state evenly into power-of-two groups
  function automatic bit legal_lanes(input int lanes);
    return (lanes == 1) || (lanes == 2) || (lanes == 4) ||
           (lanes == 8) || (lanes == 16);
  endfunction

endpackage

// File: rtl/sbox_lane.sv
// One registered AES S-box lookup: the output appears one clock after the input byte.
// Optional feature macro: SUBBYTES_INV_EN (adds the inverse table and the inv select).
module sbox_lane
  import aes_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
`ifdef SUBBYTES_INV_EN
  input  logic      inv,
`endif
  input  aes_byte_t din,
  output aes_byte_t dout
);

  localparam logic [0:255][7:0] FWD_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

`ifdef SUBBYTES_INV_EN
  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };
`endif

  aes_byte_t dout_d;
  aes_byte_t dout_q;

  // Table lookup for the byte currently presented to this lane
  always_comb begin
    dout_d = FWD_SBOX[din];
`ifdef SUBBYTES_INV_EN
    if (inv) begin
      dout_d = INV_SBOX[din];
    end
`endif
  end

  // Register the lookup so the lane behaves as a one-cycle synchronous ROM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= '0;
    end else begin
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/subbytes_seq.sv
// Handshaked AES SubBytes stage that walks the 16 state bytes through LANES S-box lanes.
// Optional feature macro: SUBBYTES_INV_EN (decrypt port, inverse S-box per block).
module subbytes_seq
  import aes_pkg::*;
#(
  parameter int LANES = 16
) (
  input  logic         int_osc,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
`ifdef SUBBYTES_INV_EN
  input  logic         decrypt,
`endif
  output logic         busy
);

  localparam int GROUPS = 16 / LANES;
  localparam int GW     = $clog2(GROUPS) + 1;

  if (!legal_lanes(LANES)) begin : g_bad_lanes
    $error("subbytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  sb_state_e     state_d, state_q;
  logic [GW-1:0] grp_d, grp_q;
  logic [GW-1:0] wb_grp_d, wb_grp_q;
  logic          wb_en_d, wb_en_q;
  aes_state_t    block_d, block_q;
  aes_state_t    result_d, result_q;
  logic          in_ready_d, in_ready_q;
  logic          out_valid_d, out_valid_q;
  logic          busy_d, busy_q;
`ifdef SUBBYTES_INV_EN
  logic          mode_d, mode_q;
`endif

  aes_byte_t lane_in  [LANES];
  aes_byte_t lane_out [LANES];

  // Sequencing: accept a block, issue one lane group per cycle, drain, then hold the result
  always_comb begin
    state_d  = state_q;
    grp_d    = grp_q;
    block_d  = block_q;
    wb_en_d  = (state_q == ISSUE);
    wb_grp_d = grp_q;
`ifdef SUBBYTES_INV_EN
    mode_d   = mode_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          block_d = state_in;
          grp_d   = '0;
          state_d = ISSUE;
`ifdef SUBBYTES_INV_EN
          mode_d  = decrypt;
`endif
        end
      end
      ISSUE: begin
        grp_d = grp_q + GW'(1);
        if (grp_q == GW'(GROUPS - 1)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: state_d = DONE;
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  // Route the current group's bytes to the lanes; idle lanes see zero
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      lane_in[i] = 8'h00;
    end
    if (state_q == ISSUE) begin
      for (int g = 0; g < GROUPS; g++) begin
        if (grp_q == GW'(g)) begin
          for (int i = 0; i < LANES; i++) begin
            lane_in[i] = block_q[127 - 8 * (g * LANES + i) -: 8];
          end
        end
      end
    end
  end

  // Lane results land one cycle after issue, back into the byte slots they came from
  always_comb begin
    result_d = result_q;
    if (wb_en_q) begin
      for (int g = 0; g < GROUPS; g++) begin
        if (wb_grp_q == GW'(g)) begin
          for (int i = 0; i < LANES; i++) begin
            result_d[127 - 8 * (g * LANES + i) -: 8] = lane_out[i];
          end
        end
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    sbox_lane u_lane (
      .clk  (int_osc),
      .rst_n(reset),
`ifdef SUBBYTES_INV_EN
      .inv  (mode_q),
`endif
      .din  (lane_in[i]),
      .dout (lane_out[i])
    );
  end

  // State, datapath and registered handshake outputs; reset drops any partial block
  always_ff @(posedge int_osc or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      grp_q       <= '0;
      wb_grp_q    <= '0;
      wb_en_q     <= 1'b0;
      block_q     <= '0;
      result_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SUBBYTES_INV_EN
      mode_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      grp_q       <= grp_d;
      wb_grp_q    <= wb_grp_d;
      wb_en_q     <= wb_en_d;
      block_q     <= block_d;
      result_q    <= result_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
`ifdef SUBBYTES_INV_EN
      mode_q      <= mode_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign state_out = result_q;

endmodule

// File: tb/tb_subbytes_seq.sv
// Directed bench for subbytes_seq built with four lanes (four issue groups per block).
// Optional feature macro: SUBBYTES_INV_EN (adds the decrypt scenario).
module tb_subbytes_seq;

   localparam int TB_LANES  = 4;
   localparam int TB_GROUPS = 16 / TB_LANES;

   localparam logic [127:0] VEC_PLAIN = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] VEC_SUB   = 128'h638293c31bfc33f5c4eeacea4bc12816;
   localparam logic [127:0] ZERO_SUB  = {16{8'h63}};
   localparam logic [127:0] ONES_SUB  = {16{8'h16}};
   localparam logic [127:0] ONE       = 128'd1;
   localparam logic [127:0] ZERO      = 128'd0;

   logic         clock = 1'b0;
   logic         resetN = 1'b0;
   logic         inValid = 1'b0;
   logic         inReady;
   logic [127:0] stateIn = '0;
   logic         outValid;
   logic         outReady = 1'b0;
   logic [127:0] stateOut;
   logic         busy;
`ifdef SUBBYTES_INV_EN
   logic         decrypt = 1'b0;
`endif

   int checkCount = 0;
   int errorCount = 0;

   int           latency;
   int           firstValid;
   int           rise1;
   int           rise2;
   logic         prevValid;
   logic [127:0] val1;
   logic [127:0] val2;

   // Free-running clock, 10 time units per period
   always #5 clock = ~clock;

   subbytes_seq #(.LANES(TB_LANES)) dut (
      .int_osc  (clock),
      .reset    (resetN),
      .in_valid (inValid),
      .in_ready (inReady),
      .state_in (stateIn),
      .out_valid(outValid),
      .out_ready(outReady),
      .state_out(stateOut),
`ifdef SUBBYTES_INV_EN
      .decrypt  (decrypt),
`endif
      .busy     (busy)
   );

   // Count a comparison and report it when the observed value differs
   task automatic checkOutput(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   // Present one block and return just after the edge that accepts it
   task automatic applyStimulus(input logic [127:0] blk);
      int waitCycles;
      @(negedge clock);
      stateIn = blk;
      inValid = 1'b1;
      waitCycles = 0;
      while (!inReady && waitCycles < 50) begin
         @(negedge clock);
         waitCycles++;
      end
      checkOutput("accept_ready", 128'(inReady), ONE);
      @(posedge clock);
      #1;
      inValid = 1'b0;
   endtask

   // Count cycles after the accept edge until out_valid is seen, bounded
   task automatic waitOutValid(output int cycles);
      cycles = 0;
      do begin
         @(negedge clock);
         cycles++;
      end while (!outValid && cycles < 60);
   endtask

   // Scenario sequence: reset, latency, hold, mid-block reset, back-to-back, inverse
   initial begin
      $display("[TB] start, LANES=%0d", TB_LANES);

      repeat (3) @(negedge clock);
      checkOutput("in_reset_valid", 128'(outValid), ZERO);
      resetN = 1'b1;
      @(negedge clock);
      checkOutput("rst_in_ready", 128'(inReady), ONE);
      checkOutput("rst_out_valid", 128'(outValid), ZERO);
      checkOutput("rst_busy", 128'(busy), ZERO);
      checkOutput("rst_state_out", stateOut, ZERO);

      outReady = 1'b1;
      applyStimulus(VEC_PLAIN);
      firstValid = -1;
      for (int n = 1; n <= TB_GROUPS + 2; n++) begin
         @(negedge clock);
         checkOutput("busy_in_block", 128'(busy), ONE);
         checkOutput("in_ready_low", 128'(inReady), ZERO);
         if (outValid && firstValid < 0) firstValid = n;
      end
      checkOutput("latency", 128'(firstValid), 128'(TB_GROUPS + 2));
      checkOutput("result_plain", stateOut, VEC_SUB);
      @(negedge clock);
      checkOutput("ready_after_take", 128'(inReady), ONE);
      checkOutput("valid_drop", 128'(outValid), ZERO);
      checkOutput("idle_busy", 128'(busy), ZERO);

      outReady = 1'b0;
      applyStimulus(128'h0);
      waitOutValid(latency);
      checkOutput("hold_latency", 128'(latency), 128'(TB_GROUPS + 2));
      for (int n = 0; n < 10; n++) begin
         checkOutput("hold_result", stateOut, ZERO_SUB);
         checkOutput("hold_valid", 128'(outValid), ONE);
         checkOutput("hold_in_ready", 128'(inReady), ZERO);
         if (n == 3) begin
            inValid = 1'b1;
            stateIn = '1;
         end
         if (n == 4) inValid = 1'b0;
         @(negedge clock);
      end
      outReady = 1'b1;
      @(negedge clock);
      checkOutput("release_valid", 128'(outValid), ZERO);
      checkOutput("release_ready", 128'(inReady), ONE);
      repeat (3) @(negedge clock);
      checkOutput("ignored_pulse_idle", 128'(busy), ZERO);
      applyStimulus('1);
      waitOutValid(latency);
      checkOutput("second_latency", 128'(latency), 128'(TB_GROUPS + 2));
      checkOutput("second_result", stateOut, ONES_SUB);
      @(negedge clock);

      applyStimulus(VEC_PLAIN);
      repeat (2) @(negedge clock);
      resetN = 1'b0;
      @(negedge clock);
      checkOutput("midreset_busy", 128'(busy), ZERO);
      resetN = 1'b1;
      #1;
      checkOutput("midreset_valid", 128'(outValid), ZERO);
      checkOutput("midreset_state", stateOut, ZERO);
      checkOutput("midreset_ready", 128'(inReady), ONE);
      repeat (TB_GROUPS + 3) begin
         @(negedge clock);
         checkOutput("midreset_no_pulse", 128'(outValid), ZERO);
      end
      applyStimulus(VEC_PLAIN);
      waitOutValid(latency);
      checkOutput("post_reset_latency", 128'(latency), 128'(TB_GROUPS + 2));
      checkOutput("post_reset_result", stateOut, VEC_SUB);
      @(negedge clock);

      @(negedge clock);
      stateIn = '0;
      inValid = 1'b1;
      rise1 = -1;
      rise2 = -1;
      prevValid = 1'b0;
      val1 = '0;
      val2 = '0;
      for (int n = 1; n <= 2 * (TB_GROUPS + 3) + 2; n++) begin
         @(negedge clock);
         if (n == 1) stateIn = '1;
         if (outValid && !prevValid) begin
            if (rise1 < 0) begin
               rise1 = n;
               val1 = stateOut;
            end else if (rise2 < 0) begin
               rise2 = n;
               val2 = stateOut;
            end
         end
         prevValid = outValid;
      end
      inValid = 1'b0;
      checkOutput("b2b_first_rise", 128'(rise1), 128'(TB_GROUPS + 2));
      checkOutput("b2b_spacing", 128'(rise2 - rise1), 128'(TB_GROUPS + 3));
      checkOutput("b2b_first_value", val1, ZERO_SUB);
      checkOutput("b2b_second_value", val2, ONES_SUB);
      waitOutValid(latency);
      checkOutput("b2b_third_value", stateOut, ONES_SUB);
      repeat (2) @(negedge clock);

`ifdef SUBBYTES_INV_EN
      decrypt = 1'b1;
      applyStimulus(VEC_SUB);
      repeat (2) @(negedge clock);
      decrypt = 1'b0;
      waitOutValid(latency);
      checkOutput("inverse_result", stateOut, VEC_PLAIN);
      @(negedge clock);
      applyStimulus(VEC_PLAIN);
      waitOutValid(latency);
      checkOutput("forward_after_inverse", stateOut, VEC_SUB);
      @(negedge clock);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
